// File: rtl/ttest_mul_share_arb.sv
// Round-robin sharing of one combinational unsigned multiplier among several
// requesters. S1 holds the granted operands and drives the multiplier; S2
// captures the product and presents it on a backpressured response channel.
module ttest_mul_share_arb #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int OP_W    = 23,
    parameter int RES_W   = 46
) (
    input  logic                    ap_clk,
    input  logic                    ap_rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*OP_W-1:0] req_a,
    input  logic [NUM_REQ*OP_W-1:0] req_b,
    output logic [OP_W-1:0]         mul_din0,
    output logic [OP_W-1:0]         mul_din1,
    input  logic [RES_W-1:0]        mul_dout,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [ID_W-1:0]         rsp_id,
    output logic [RES_W-1:0]        rsp_data,
    output logic [31:0]             op_count
);

    localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);

    // S1 (operand) stage
    logic            op_v_reg;
    logic [ID_W-1:0] op_id_reg;
    logic [OP_W-1:0] op_a_reg;
    logic [OP_W-1:0] op_b_reg;

    // S2 (response) stage
    logic             rsp_valid_reg;
    logic [ID_W-1:0]  rsp_id_reg;
    logic [RES_W-1:0] rsp_data_reg;

    logic [31:0]     op_count_reg;
    logic [ID_W-1:0] ptr_reg;
    logic [ID_W-1:0] ptr_next;

    // Arbitration results
    logic [OP_W-1:0]    a_arr [NUM_REQ];
    logic [OP_W-1:0]    b_arr [NUM_REQ];
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_id;
    logic               grant_any;
    logic [ID_W-1:0]    scan_idx;

    logic adv;
    logic can_acc;
    logic fire;

    // S1 moves into S2 whenever S2 is empty or being drained this cycle
    assign adv     = op_v_reg & (~rsp_valid_reg | rsp_ready);
    assign can_acc = ~op_v_reg | adv;
    assign fire    = grant_any & can_acc & ~ap_rst;

    // Unpack operands and form the per-requester accept; ready is held low
    // while reset is asserted so nothing is handed over during reset.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign a_arr[gi]     = req_a[gi*OP_W +: OP_W];
            assign b_arr[gi]     = req_b[gi*OP_W +: OP_W];
            assign req_ready[gi] = grant[gi] & can_acc & ~ap_rst;
        end
    endgenerate

    // Round-robin search starting at ptr, wrapping at NUM_REQ-1
    always_comb begin
        grant     = '0;
        grant_id  = '0;
        grant_any = 1'b0;
        scan_idx  = ptr_reg;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!grant_any && req_valid[scan_idx]) begin
                grant_any       = 1'b1;
                grant[scan_idx] = 1'b1;
                grant_id        = scan_idx;
            end
            scan_idx = (scan_idx == LAST_ID) ? '0 : scan_idx + 1'b1;
        end
    end

    // Pointer moves to the slot just after the winner
    always_comb begin
        ptr_next = ptr_reg;
        if (fire) begin
            ptr_next = (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
        end
    end

    // Round-robin pointer register
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            ptr_reg <= '0;
        end else begin
            ptr_reg <= ptr_next;
        end
    end

    // S1: capture the granted request's operands and owner
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            op_v_reg  <= 1'b0;
            op_id_reg <= '0;
            op_a_reg  <= '0;
            op_b_reg  <= '0;
        end else begin
            if (fire) begin
                op_id_reg <= grant_id;
                op_a_reg  <= a_arr[grant_id];
                op_b_reg  <= b_arr[grant_id];
            end
            op_v_reg <= fire | (op_v_reg & ~adv);
        end
    end

    // S2: take the product straight off the combinational multiplier
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            rsp_valid_reg <= 1'b0;
            rsp_id_reg    <= '0;
            rsp_data_reg  <= '0;
        end else begin
            if (adv) begin
                rsp_id_reg   <= op_id_reg;
                rsp_data_reg <= mul_dout;
            end
            rsp_valid_reg <= adv | (rsp_valid_reg & ~rsp_ready);
        end
    end

    // Completed-response counter, sticks at all-ones
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            op_count_reg <= '0;
        end else if (rsp_valid_reg && rsp_ready && (op_count_reg != 32'hFFFF_FFFF)) begin
            op_count_reg <= op_count_reg + 32'd1;
        end
    end

    assign mul_din0  = op_a_reg;
    assign mul_din1  = op_b_reg;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_id    = rsp_id_reg;
    assign rsp_data  = rsp_data_reg;
    assign op_count  = op_count_reg;

endmodule

// File: tb/tb_ttest_mul_share_arb.sv
// Bench for ttest_mul_share_arb: directed scenarios plus random traffic,
// every cycle compared against a transaction-level model (in-flight queue,
// round-robin pointer, response counter).
module tb_ttest_mul_share_arb;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;
    localparam int OP_W    = 23;
    localparam int RES_W   = 46;
    localparam logic [OP_W-1:0] OP_MAX = 23'h7FFFFF;

    logic                    ap_clk = 1'b0;
    logic                    ap_rst;
    logic [NUM_REQ-1:0]      req_valid;
    logic [NUM_REQ-1:0]      req_ready;
    logic [NUM_REQ*OP_W-1:0] req_a;
    logic [NUM_REQ*OP_W-1:0] req_b;
    logic [OP_W-1:0]         mul_din0;
    logic [OP_W-1:0]         mul_din1;
    logic [RES_W-1:0]        mul_dout;
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [ID_W-1:0]         rsp_id;
    logic [RES_W-1:0]        rsp_data;
    logic [31:0]             op_count;

    always #5 ap_clk = ~ap_clk;

    // The shared multiplier itself (combinational, no pipeline)
    assign mul_dout = RES_W'(mul_din0) * RES_W'(mul_din1);

    ttest_mul_share_arb #(
        .NUM_REQ(NUM_REQ), .ID_W(ID_W), .OP_W(OP_W), .RES_W(RES_W)
    ) dut (
        .ap_clk   (ap_clk),
        .ap_rst   (ap_rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_a    (req_a),
        .req_b    (req_b),
        .mul_din0 (mul_din0),
        .mul_din1 (mul_din1),
        .mul_dout (mul_dout),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_id   (rsp_id),
        .rsp_data (rsp_data),
        .op_count (op_count)
    );

    typedef struct {
        int          id;
        logic [63:0] prod;
        int          acc_edge;
    } item_t;

    // Reference model state
    item_t       q[$];
    int          m_ptr;
    logic [31:0] m_cnt;
    int          edge_n;

    // Requester-side state
    logic            pend_v [NUM_REQ];
    logic [OP_W-1:0] pend_a [NUM_REQ];
    logic [OP_W-1:0] pend_b [NUM_REQ];
    bit              auto_gen;
    int              req_pct;
    int              rsp_mode;   // 0 = hold low, 1 = hold high, 2 = random
    int              dut_acc;

    int n_pass;
    int n_total;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_total++;
        assert (obs === exp_v) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [OP_W-1:0] rand_op();
        case ($urandom % 4)
            0:       return '0;
            1:       return OP_MAX;
            default: return OP_W'($urandom);
        endcase
    endfunction

    task automatic apply();
        for (int i = 0; i < NUM_REQ; i++) begin
            req_valid[i]             = pend_v[i];
            req_a[i*OP_W +: OP_W]    = pend_a[i];
            req_b[i*OP_W +: OP_W]    = pend_b[i];
        end
    endtask

    task automatic set_req(input int i, input logic [OP_W-1:0] a, input logic [OP_W-1:0] b);
        pend_v[i] = 1'b1;
        pend_a[i] = a;
        pend_b[i] = b;
        apply();
    endtask

    // One clock: compare at the falling edge, advance the model at the
    // rising edge, then refresh requesters and rsp_ready just after it.
    task automatic step();
        int                 g;
        int                 idx;
        bit                 acc;
        bit                 rv;
        logic [NUM_REQ-1:0] er;
        item_t              it;
        @(negedge ap_clk);
        g = -1;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (m_ptr + k) % NUM_REQ;
            if (g < 0 && req_valid[idx]) g = idx;
        end
        acc = (g >= 0) && ((q.size() < 2) || rsp_ready);
        er  = '0;
        if (acc) er[g] = 1'b1;
        rv = (q.size() > 0) && ((edge_n - q[0].acc_edge) >= 2);
        chk("req_ready", 64'(req_ready), 64'(er));
        chk("rsp_valid", 64'(rsp_valid), 64'(rv));
        if (rv) begin
            chk("rsp_id", 64'(rsp_id), 64'(q[0].id));
            chk("rsp_data", 64'(rsp_data), q[0].prod);
        end
        chk("op_count", 64'(op_count), 64'(m_cnt));
        dut_acc += $countones(req_valid & req_ready);
        @(posedge ap_clk);
        if (rv && rsp_ready) begin
            $display("rsp id=%0d data=0x%0h count=%0d", q[0].id, q[0].prod, m_cnt);
            void'(q.pop_front());
            if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
        end
        if (acc) begin
            it.id       = g;
            it.prod     = longint'(pend_a[g]) * longint'(pend_b[g]);
            it.acc_edge = edge_n;
            q.push_back(it);
            m_ptr     = (g + 1) % NUM_REQ;
            pend_v[g] = 1'b0;
        end
        edge_n++;
        #1;
        if (auto_gen) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!pend_v[i] && ($urandom % 100) < req_pct) begin
                    pend_v[i] = 1'b1;
                    pend_a[i] = rand_op();
                    pend_b[i] = rand_op();
                end
            end
        end
        case (rsp_mode)
            0:       rsp_ready = 1'b0;
            1:       rsp_ready = 1'b1;
            default: rsp_ready = 1'($urandom % 2);
        endcase
        apply();
    endtask

    task automatic drain();
        auto_gen = 1'b0;
        rsp_mode = 1;
        rsp_ready = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) pend_v[i] = 1'b0;
        apply();
        for (int n = 0; n < 8; n++) begin
            if (q.size() > 0) step();
        end
    endtask

    initial begin
        n_pass   = 0;
        n_total  = 0;
        m_ptr    = 0;
        m_cnt    = '0;
        edge_n   = 0;
        auto_gen = 1'b0;
        req_pct  = 0;
        rsp_mode = 1;
        dut_acc  = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            pend_v[i] = 1'b0;
            pend_a[i] = '0;
            pend_b[i] = '0;
        end
        apply();
        rsp_ready = 1'b1;
        ap_rst    = 1'b1;

        // Reset state
        #2;
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_op_count", 64'(op_count), 64'd0);
        chk("rst_din0", 64'(mul_din0), 64'd0);
        chk("rst_din1", 64'(mul_din1), 64'd0);
        @(posedge ap_clk);
        #1 ap_rst = 1'b0;

        // Single request from requester 2: 3 * 5
        set_req(2, 23'd3, 23'd5);
        for (int n = 0; n < 4; n++) step();
        chk("single_count", 64'(op_count), 64'd1);

        // Full contention: grants rotate 0,1,2,3,0,...
        drain();
        auto_gen = 1'b1;
        req_pct  = 100;
        for (int i = 0; i < NUM_REQ; i++) set_req(i, rand_op(), rand_op());
        for (int n = 0; n < 12; n++) step();

        // Backpressure: five stalled cycles admit exactly two requests
        drain();
        auto_gen  = 1'b1;
        req_pct   = 100;
        rsp_mode  = 0;
        rsp_ready = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) set_req(i, rand_op(), rand_op());
        dut_acc = 0;
        for (int n = 0; n < 5; n++) step();
        chk("bp_accepts", 64'(dut_acc), 64'd2);
        rsp_mode = 1;
        for (int n = 0; n < 6; n++) step();

        // Width corners
        drain();
        set_req(1, OP_MAX, OP_MAX);
        set_req(3, '0, OP_MAX);
        for (int n = 0; n < 5; n++) step();

        // Random traffic with random backpressure
        auto_gen = 1'b1;
        req_pct  = 60;
        rsp_mode = 2;
        for (int n = 0; n < 300; n++) step();

        // Reset while both stages are full
        rsp_mode  = 0;
        req_pct   = 100;
        rsp_ready = 1'b0;
        for (int n = 0; n < 4; n++) step();
        #2 ap_rst = 1'b1;
        #1;
        chk("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("midrst_req_ready", 64'(req_ready), 64'd0);
        chk("midrst_op_count", 64'(op_count), 64'd0);
        chk("midrst_din0", 64'(mul_din0), 64'd0);
        q.delete();
        m_ptr = 0;
        m_cnt = '0;
        @(posedge ap_clk);
        #1;
        chk("midrst_hold_valid", 64'(rsp_valid), 64'd0);
        ap_rst    = 1'b0;
        rsp_mode  = 1;
        rsp_ready = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!pend_v[i]) set_req(i, rand_op(), rand_op());
        end
        for (int n = 0; n < 8; n++) step();

        // Counter saturation
        drain();
        force dut.op_count_reg = 32'hFFFF_FFFE;
        #1 release dut.op_count_reg;
        m_cnt    = 32'hFFFF_FFFE;
        auto_gen = 1'b1;
        req_pct  = 100;
        for (int i = 0; i < NUM_REQ; i++) set_req(i, rand_op(), rand_op());
        for (int n = 0; n < 8; n++) step();
        chk("sat_count", 64'(op_count), 64'hFFFF_FFFF);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
